// File: rtl/decodificador_serial_pkg.sv
// decodificador_pkg: shared FSM states, 7-segment patterns and frame constants.
// Segment constants are active-high a..g in [0:6] order; the display outputs invert them.
package decodificador_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [0:6] SEG_0 = 7'b1111110;
  localparam logic [0:6] SEG_1 = 7'b0110000;
  localparam logic [0:6] SEG_2 = 7'b1101101;
  localparam logic [0:6] SEG_3 = 7'b1111001;
  localparam logic [0:6] SEG_4 = 7'b0110011;
  localparam logic [0:6] SEG_5 = 7'b1011011;
  localparam logic [0:6] SEG_6 = 7'b1011111;
  localparam logic [0:6] SEG_7 = 7'b1110000;
  localparam logic [0:6] SEG_8 = 7'b1111111;
  localparam logic [0:6] SEG_9 = 7'b1110011;
  localparam logic [0:6] SEG_DASH = 7'b0000001;
  localparam logic [0:6] SEG_OFF = 7'b0000000;
  localparam int FRAME_BITS = 7;
  function automatic logic [0:6] seg_of(input logic [3:0] d);
    return d == 4'd0 ? SEG_0 : d == 4'd1 ? SEG_1 : d == 4'd2 ? SEG_2 :
           d == 4'd3 ? SEG_3 : d == 4'd4 ? SEG_4 : d == 4'd5 ? SEG_5 :
           d == 4'd6 ? SEG_6 : d == 4'd7 ? SEG_7 : d == 4'd8 ? SEG_8 :
           d == 4'd9 ? SEG_9 : SEG_OFF;
  endfunction
endpackage

// File: rtl/decodificador_serial_if.sv
// decodificador_serial_if: serial link and decoded/display outputs of the receiver.
// slave: the receiver (drives code/ready/frame_ok/erro/dse/dsd); master: line driver and observer.
interface decodificador_serial_if;
  logic serial_in;
  logic [3:0] code;
  logic ready;
  logic frame_ok;
  logic erro;
  logic [0:6] dse;
  logic [0:6] dsd;
  modport master(output serial_in, input code, ready, frame_ok, erro, dse, dsd);
  modport slave(input serial_in, output code, ready, frame_ok, erro, dse, dsd);
endinterface

// File: rtl/seg7_digito.sv
// seg7_digito: decimal digit 0..9 to active-low 7-segment pattern.
// Ports: digito (4-bit digit in), seg ([0:6] segments a..g, active-low; blank above 9).
module seg7_digito
  import decodificador_pkg::*;
(
  input  logic [3:0] digito,
  output logic [0:6] seg
);
  assign seg = ~seg_of(digito);
endmodule

// File: rtl/decodificador_serial.sv
// decodificador_serial: serial frame receiver with even-parity/stop check and 2-digit display.
// Ports: clk, reset (async active-high), bus (slave modport: serial_in in; code, ready,
// frame_ok, erro, dse, dsd out). Frame: start(1), S3..S0, even parity, stop(0).
module decodificador_serial
  import decodificador_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  decodificador_serial_if.slave bus
);
  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int DATA_BITS = FRAME_BITS - 3;
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [3:0] shreg;
  logic par_bit;
  logic pend;
  logic pend_ok;
  logic tick;
  logic ge10;
  logic [3:0] units;
  logic [0:6] units_seg;
  logic [0:6] tens_seg;
  assign tick = cnt == '0;
  assign ge10 = shreg >= 4'd10;
  assign units = ge10 ? shreg - 4'd10 : shreg;
  seg7_digito u_units (.digito(units), .seg(units_seg));
  seg7_digito u_tens (.digito({3'b000, ge10}), .seg(tens_seg));
  // Every sample point sits mid-bit: START waits half a bit, later bits a full bit each.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      pend <= 1'b0;
      pend_ok <= 1'b0;
    end else begin
      pend <= 1'b0;
      case (state)
        IDLE: if (bus.serial_in) begin
          state <= START;
          cnt <= HALF;
        end
        START: if (!tick) cnt <= cnt - 1'b1;
        else if (!bus.serial_in) state <= IDLE;
        else begin
          state <= DATA;
          cnt <= FULL;
          idx <= 2'(DATA_BITS - 1);
        end
        DATA: if (!tick) cnt <= cnt - 1'b1;
        else begin
          shreg <= {shreg[2:0], bus.serial_in};
          cnt <= FULL;
          idx <= idx - 1'b1;
          if (idx == 2'd0) state <= PARITY;
        end
        PARITY: if (!tick) cnt <= cnt - 1'b1;
        else begin
          par_bit <= bus.serial_in;
          cnt <= FULL;
          state <= STOP;
        end
        STOP: if (!tick) cnt <= cnt - 1'b1;
        else begin
          state <= IDLE;
          pend <= 1'b1;
          pend_ok <= !bus.serial_in && ((^shreg) == par_bit);
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Results land one edge after the stop sample, while the FSM already listens in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.code <= '0;
      bus.ready <= 1'b0;
      bus.frame_ok <= 1'b0;
      bus.erro <= 1'b0;
      bus.dse <= ~SEG_DASH;
      bus.dsd <= ~SEG_DASH;
    end else begin
      bus.frame_ok <= pend && pend_ok;
      if (pend && pend_ok) begin
        bus.code <= shreg;
        bus.ready <= 1'b1;
        bus.erro <= 1'b0;
        bus.dse <= ge10 ? tens_seg : ~SEG_OFF;
        bus.dsd <= units_seg;
      end else if (pend) begin
        bus.erro <= 1'b1;
        bus.dse <= ~SEG_DASH;
        bus.dsd <= ~SEG_DASH;
      end
    end
  end
endmodule

// File: tb/tb_decodificador_serial.sv
// tb_decodificador_serial: directed vector bench for the serial decoder (BIT_CYCLES = 4).
module tb_decodificador_serial;
  import decodificador_pkg::*;
  localparam int BC = 4;
  localparam logic [6:0] DASH = 7'b1111110;
  localparam logic [6:0] BLNK = 7'b1111111;
  localparam logic [6:0] ONE = 7'b1001111;
  typedef struct {
    logic [3:0] data;
    logic par;
    logic stp;
    int gap;
    logic ok;
    logic [3:0] code;
    logic ready;
    logic erro;
    logic [6:0] dse;
    logic [6:0] dsd;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  vec_t vecs[20];
  always #5 clk = ~clk;
  decodificador_serial_if bus();
  decodificador_serial #(.BIT_CYCLES(BC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(negedge clk) if (bus.frame_ok === 1'b1) pulses++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b", name, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] code, input logic ready,
                         input logic erro, input logic [6:0] dse, input logic [6:0] dsd);
    chk({tag, ".code"}, 32'(bus.code), 32'(code));
    chk({tag, ".ready"}, 32'(bus.ready), 32'(ready));
    chk({tag, ".erro"}, 32'(bus.erro), 32'(erro));
    chk({tag, ".dse"}, 32'(bus.dse), 32'(dse));
    chk({tag, ".dsd"}, 32'(bus.dsd), 32'(dsd));
  endtask
  task automatic send(input logic [3:0] d, input logic p, input logic s);
    logic [FRAME_BITS-1:0] f;
    f = {1'b1, d, p, s};
    for (int i = FRAME_BITS - 1; i >= 0; i--) begin
      bus.serial_in = f[i];
      repeat (BC) @(posedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int p0;
    vecs = '{
      '{4'hD, 1'b1, 1'b0, 0, 1'b1, 4'hD, 1'b1, 1'b0, ONE,  7'b0000110},
      '{4'h5, 1'b0, 1'b0, 0, 1'b1, 4'h5, 1'b1, 1'b0, BLNK, 7'b0100100},
      '{4'h5, 1'b1, 1'b0, 0, 1'b0, 4'h5, 1'b1, 1'b1, DASH, DASH},
      '{4'h5, 1'b0, 1'b0, 0, 1'b1, 4'h5, 1'b1, 1'b0, BLNK, 7'b0100100},
      '{4'hA, 1'b0, 1'b1, 8, 1'b0, 4'h5, 1'b1, 1'b1, DASH, DASH},
      '{4'hF, 1'b0, 1'b0, 0, 1'b1, 4'hF, 1'b1, 1'b0, ONE,  7'b0100100},
      '{4'h9, 1'b0, 1'b0, 0, 1'b1, 4'h9, 1'b1, 1'b0, BLNK, 7'b0001100},
      '{4'hA, 1'b0, 1'b0, 0, 1'b1, 4'hA, 1'b1, 1'b0, ONE,  7'b0000001},
      '{4'h0, 1'b0, 1'b0, 0, 1'b1, 4'h0, 1'b1, 1'b0, BLNK, 7'b0000001},
      '{4'h7, 1'b1, 1'b0, 0, 1'b1, 4'h7, 1'b1, 1'b0, BLNK, 7'b0001111},
      '{4'h8, 1'b1, 1'b0, 0, 1'b1, 4'h8, 1'b1, 1'b0, BLNK, 7'b0000000},
      '{4'h6, 1'b0, 1'b0, 0, 1'b1, 4'h6, 1'b1, 1'b0, BLNK, 7'b0100000},
      '{4'h2, 1'b1, 1'b0, 0, 1'b1, 4'h2, 1'b1, 1'b0, BLNK, 7'b0010010},
      '{4'h4, 1'b1, 1'b0, 0, 1'b1, 4'h4, 1'b1, 1'b0, BLNK, 7'b1001100},
      '{4'h1, 1'b1, 1'b0, 0, 1'b1, 4'h1, 1'b1, 1'b0, BLNK, 7'b1001111},
      '{4'hC, 1'b0, 1'b0, 0, 1'b1, 4'hC, 1'b1, 1'b0, ONE,  7'b0010010},
      '{4'hB, 1'b1, 1'b0, 0, 1'b1, 4'hB, 1'b1, 1'b0, ONE,  7'b1001111},
      '{4'hE, 1'b1, 1'b0, 0, 1'b1, 4'hE, 1'b1, 1'b0, ONE,  7'b1001100},
      '{4'h3, 1'b0, 1'b0, 0, 1'b1, 4'h3, 1'b1, 1'b0, BLNK, 7'b0000110},
      '{4'hD, 1'b1, 1'b0, 0, 1'b1, 4'hD, 1'b1, 1'b0, ONE,  7'b0000110}
    };
    bus.serial_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_out("reset", 4'h0, 1'b0, 1'b0, DASH, DASH);
    chk("reset.frame_ok", 32'(bus.frame_ok), 32'd0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    chk_out("idle", 4'h0, 1'b0, 1'b0, DASH, DASH);
    chk("idle.pulses", 32'(pulses), 32'd0);
    foreach (vecs[k]) begin
      p0 = pulses;
      send(vecs[k].data, vecs[k].par, vecs[k].stp);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d.frame_ok", k), 32'(bus.frame_ok), 32'(vecs[k].ok));
      chk($sformatf("v%0d.pulses", k), 32'(pulses - p0), 32'(vecs[k].ok));
      chk_out($sformatf("v%0d", k), vecs[k].code, vecs[k].ready, vecs[k].erro, vecs[k].dse, vecs[k].dsd);
      bus.serial_in = 1'b0;
      repeat (vecs[k].gap) @(negedge clk);
    end
    p0 = pulses;
    bus.serial_in = 1'b1;
    @(negedge clk);
    bus.serial_in = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("glitch.pulses", 32'(pulses - p0), 32'd0);
    chk_out("glitch", 4'hD, 1'b1, 1'b0, ONE, 7'b0000110);
    p0 = pulses;
    send(4'h9, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("after_glitch.pulses", 32'(pulses - p0), 32'd1);
    chk_out("after_glitch", 4'h9, 1'b1, 1'b0, BLNK, 7'b0001100);
    bus.serial_in = 1'b0;
    repeat (3) @(negedge clk);
    p0 = pulses;
    bus.serial_in = 1'b1;
    repeat (BC) @(posedge clk);
    #1;
    bus.serial_in = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_out("midreset", 4'h0, 1'b0, 1'b0, DASH, DASH);
    chk("midreset.frame_ok", 32'(bus.frame_ok), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("midreset.pulses", 32'(pulses - p0), 32'd0);
    chk_out("midreset_tail", 4'h0, 1'b0, 1'b0, DASH, DASH);
    p0 = pulses;
    send(4'hD, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("recover.pulses", 32'(pulses - p0), 32'd1);
    chk_out("recover", 4'hD, 1'b1, 1'b0, ONE, 7'b0000110);
    bus.serial_in = 1'b0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
